// File: rtl/fir_mac.sv
// Sequential single-multiplier FIR stage: one tap per cycle into a wide
// accumulator, then a sign-magnitude, 32-bit saturated result with a done strobe.
module fir_mac #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic                      sample_valid,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy,
  output logic [31:0]               dataout,
  output logic                      sign,
  output logic                      overout,
  output logic                      sat
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state, state_nx;
  logic                      enable_p1, en_rise;
  logic                      accept, mac_step, done_fire, coef_wr;
  logic [AW-1:0]             idx;
  logic signed [DATA_W-1:0]  taps  [TAPS];
  logic signed [COEF_W-1:0]  coefs [TAPS];
  logic signed [ACC_W-1:0]   acc, prod_ext;
  logic signed [PW-1:0]      prod;

  // Magnitude of the accumulator clipped to 32 bits; MSB of the return is the
  // saturation flag. The most-negative value negates to 2^(ACC_W-1) unsigned.
  function automatic logic [32:0] mag_sat(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1:0] m;
    m = a[ACC_W-1] ? -a : a;
    if (|m[ACC_W-1:32]) mag_sat = {1'b1, 32'hFFFF_FFFF};
    else                mag_sat = {1'b0, m[31:0]};
  endfunction

  assign en_rise  = enable & ~enable_p1;
  assign prod     = taps[idx] * coefs[idx];
  assign prod_ext = ACC_W'(prod);
  assign busy     = (state != IDLE);
  assign coef_wr  = coef_we & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    mac_step  = 1'b0;
    done_fire = 1'b0;
    if (!enable || en_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (sample_valid) begin
          state_nx = MAC;
          accept   = 1'b1;
        end
        MAC: begin
          mac_step = 1'b1;
          if (idx == AW'(TAPS - 1)) state_nx = DONE;
        end
        DONE: begin
          done_fire = 1'b1;
          state_nx  = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // p0: sample capture / MAC accumulation; p1: rescale into sign-magnitude output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_p1 <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        taps[k]  <= '0;
        coefs[k] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      dataout <= '0;
      sign    <= 1'b0;
      sat     <= 1'b0;
      overout <= 1'b0;
    end else begin
      enable_p1 <= enable;
      overout   <= 1'b0;
      if (coef_wr) coefs[coef_addr] <= coef_data;
      if (en_rise) begin
        for (int k = 0; k < TAPS; k++) taps[k] <= '0;
        acc     <= '0;
        idx     <= '0;
        dataout <= '0;
        sign    <= 1'b0;
        sat     <= 1'b0;
      end else begin
        if (accept) begin
          for (int k = TAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
          taps[0] <= sample_in;
          acc     <= '0;
          idx     <= '0;
        end
        if (mac_step) begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        if (done_fire) begin
          sign           <= acc[ACC_W-1];
          {sat, dataout} <= mag_sat(acc);
          overout        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac.sv
// Self-checking bench for fir_mac: table-driven impulse vectors, directed corner
// sequences and randomized samples against an arithmetic reference model.
module tb_fir_mac;
  localparam int TAPS = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               busy, sign, overout, sat;
  logic [31:0]        dataout;

  fir_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy), .dataout(dataout), .sign(sign),
    .overout(overout), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_tap [TAPS];
  int m_coef [TAPS];

  typedef struct {
    int          s;
    logic [31:0] dout;
    logic        sgn;
    logic        st;
  } vec_t;
  vec_t vecs [TAPS];

  typedef struct {
    logic [31:0] dout;
    logic        sgn;
    logic        st;
  } res_t;
  res_t exp_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model_result();
    longint a = 0;
    longint m;
    res_t r;
    for (int k = 0; k < TAPS; k++) a += longint'(m_tap[k]) * longint'(m_coef[k]);
    m = (a < 0) ? -a : a;
    r.sgn  = (a < 0);
    r.st   = (m > 64'hFFFF_FFFF);
    r.dout = r.st ? 32'hFFFF_FFFF : m[31:0];
    return r;
  endfunction

  function automatic void model_shift(input int s);
    for (int k = TAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
    m_tap[0] = s;
  endfunction

  function automatic void model_clear_line();
    for (int k = 0; k < TAPS; k++) m_tap[k] = 0;
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(val);
    tick();
    coef_we = 1'b0;
    m_coef[addr] = val;
  endtask

  task automatic wait_overout(input string name, output int c);
    c = 0;
    while (!overout && c < 4 * TAPS) begin
      tick();
      c++;
    end
    if (!overout) chk({name, "_timeout"}, 0, 1);
  endtask

  // Present one sample in IDLE, check latency, result against model and strobe width.
  task automatic process_sample(input int s, output res_t got);
    res_t e;
    int   c;
    model_shift(s);
    e = model_result();
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    wait_overout("sample", c);
    chk("latency", c, TAPS + 1);
    chk("dataout", dataout, e.dout);
    chk("sign", sign, e.sgn);
    chk("sat", sat, e.st);
    got.dout = dataout;
    got.sgn  = sign;
    got.st   = sat;
    tick();
    chk("overout_single", overout, 0);
  endtask

  task automatic pulse_enable();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    model_clear_line();
  endtask

  initial begin
    res_t r, e;
    int c, ov_seen, acc_idx;
    logic [31:0] hold_d;
    logic hold_s, hold_t;

    for (int k = 0; k < TAPS; k++) begin
      m_tap[k] = 0;
      m_coef[k] = 0;
      vecs[k].s    = (k == 0) ? 1 : 0;
      vecs[k].dout = 32'(1000 * (k + 1));
      vecs[k].sgn  = 1'b0;
      vecs[k].st   = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_dataout", dataout, 0);
    chk("rst_sign", sign, 0);
    chk("rst_overout", overout, 0);
    chk("rst_sat", sat, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();

    // Impulse through table
    for (int k = 0; k < TAPS; k++) write_coef(k, 1000 * (k + 1));
    for (int i = 0; i < TAPS; i++) begin
      process_sample(vecs[i].s, r);
      chk("imp_dout", r.dout, vecs[i].dout);
      chk("imp_sign", r.sgn, vecs[i].sgn);
      chk("imp_sat", r.st, vecs[i].st);
    end

    // Negative result
    for (int k = 0; k < TAPS; k++) write_coef(k, 10000);
    pulse_enable();
    process_sample(-3, r);
    chk("neg_dout", r.dout, 30000);
    chk("neg_sign", r.sgn, 1);

    // Saturation
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    pulse_enable();
    for (int i = 1; i <= TAPS; i++) begin
      process_sample(32767, r);
      if (i == 4) chk("sat4_flag", r.st, 0);
      if (i == 5) chk("sat5_flag", r.st, 1);
      if (i == TAPS) chk("sat8_dout", r.dout, 32'hFFFF_FFFF);
    end

    // Random coefficients and samples
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($signed(16'($urandom))));
    for (int i = 0; i < 20; i++) process_sample(int'($signed(16'($urandom))), r);

    // sample_valid held every cycle: only every (TAPS+2)th sample is accepted
    acc_idx = 0;
    for (int i = 0; i < 3 * (TAPS + 2); i++) begin
      sample_in    = 16'($urandom);
      sample_valid = 1'b1;
      if (i % (TAPS + 2) == 0) begin
        model_shift(int'(sample_in));
        exp_q.push_back(model_result());
      end
      tick();
      if (overout) begin
        if (exp_q.size() == 0) chk("drop_extra_overout", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("drop_dout", dataout, e.dout);
          chk("drop_sign", sign, e.sgn);
          acc_idx++;
        end
      end
    end
    sample_valid = 1'b0;
    chk("drop_results", acc_idx, 3);
    exp_q.delete();
    tick();

    // Coef write during MAC ignored, same write in IDLE applied
    model_shift(777);
    e = model_result();
    sample_in = 16'(777);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
    tick();
    coef_we = 1'b0;
    wait_overout("midmac", c);
    chk("midmac_dout", dataout, e.dout);
    chk("midmac_sign", sign, e.sgn);
    tick();
    write_coef(0, 5);
    process_sample(-123, r);

    // Coef write and sample in the same cycle: MAC uses the new coefficient
    m_coef[1] = -4321;
    model_shift(999);
    e = model_result();
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = -16'sd4321;
    sample_in = 16'sd999; sample_valid = 1'b1;
    tick();
    coef_we = 1'b0; sample_valid = 1'b0;
    wait_overout("same_cycle", c);
    chk("same_cycle_dout", dataout, e.dout);
    chk("same_cycle_sign", sign, e.sgn);
    tick();

    // Abort by dropping enable mid-MAC
    write_coef(0, 1234);
    process_sample(100, r);
    hold_d = dataout; hold_s = sign; hold_t = sat;
    sample_in = 16'sd50; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick(); tick();
    enable = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      tick();
      if (overout) ov_seen++;
    end
    chk("abort_overout", ov_seen, 0);
    chk("abort_hold_dout", dataout, hold_d);
    chk("abort_hold_sign", sign, hold_s);
    chk("abort_hold_sat", sat, hold_t);
    chk("abort_busy", busy, 0);
    enable = 1'b1;
    tick();
    model_clear_line();
    chk("reen_dout", dataout, 0);
    chk("reen_sign", sign, 0);
    chk("reen_sat", sat, 0);
    process_sample(-2000, r);

    // Async reset mid-MAC
    sample_in = 16'sd300; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dataout, 0);
    chk("arst_sign", sign, 0);
    chk("arst_overout", overout, 0);
    chk("arst_sat", sat, 0);
    chk("arst_busy", busy, 0);
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 0;
      m_tap[k] = 0;
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    write_coef(2, 3);
    process_sample(11, r);
    process_sample(0, r);
    process_sample(0, r);
    chk("post_rst_dout", r.dout, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
